uart_tx_arb: RTL and testbench

Round-robin scheduler that shares one UART TX serializer between NUM_REQ byte producers, for example the CPU TX FIFO, a debug monitor and a DMA channel. It picks one pending requester and launches exactly one frame into the serializer with a single-cycle start pulse. It then tracks the serializer's busy flag to frame completion and enforces an optional inter-frame idle gap. It sits between the requesters and the serializer's i_din / i_tx_start / o_active interface.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rr_pick.sv | 32 +++
 rtl/uart_tx_arb.sv | 119 +++++++++++
 tb/tb_uart_tx_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbitration slice: FSM state encodings
// and the wrap-around increment used by the round-robin pointer.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LAUNCH    = 3'd1;
    localparam state_t ST_WAIT_ACT  = 3'd2;
    localparam state_t ST_WAIT_DONE = 3'd3;
    localparam state_t ST_GAP       = 3'd4;

    // Explicit compare-and-wrap so non-power-of-2 requester counts work.
    function automatic int unsigned mod_inc(input int unsigned val, input int unsigned modulus);
        return (val + 1 >= modulus) ? 0 : val + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: returns the first set bit of valid
// found when scanning from rr_ptr upward, wrapping modulo NUM_REQ.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               any_valid,
    output logic [IDX_W-1:0]   grant
);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] sel;
        any_valid = 1'b0;
        grant     = '0;
        idx       = 0;
        sel       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = IDX_W'(idx);
            if (valid[sel]) begin
                any_valid = 1'b1;
                grant     = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one UART TX serializer between NUM_REQ producers.
//   state     | meaning
//   IDLE      | waiting for enable, a pending word and an idle serializer
//   LAUNCH    | start and ready pulses out, pointer advances, timeout loads
//   WAIT_ACT  | waiting for the serializer busy flag to rise
//   WAIT_DONE | frame in flight, waiting for busy to fall
//   GAP       | counting i_tick pulses of extra idle line
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WORD_WIDTH  = 8,
    parameter int GAP_TICKS   = 0,
    parameter int ACT_TIMEOUT = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_tick,
    input  logic                          i_enable,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [WORD_WIDTH-1:0]         o_ser_din,
    output logic                          o_ser_start,
    input  logic                          i_ser_active,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_busy,
    output logic                          o_err_stall,
    input  logic                          i_err_clr
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int TMO_W = (ACT_TIMEOUT > 0) ? $clog2(ACT_TIMEOUT + 1) : 1;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick;
    logic             any_valid;
    logic [GAP_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid     (i_req_valid),
        .rr_ptr    (rr_ptr),
        .any_valid (any_valid),
        .grant     (pick)
    );

    assign o_busy = (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            o_ser_din   <= '0;
            o_grant_id  <= '0;
            o_err_stall <= 1'b0;
            o_req_ready <= '0;
            o_ser_start <= 1'b0;
        end else begin
            o_ser_start <= 1'b0;
            o_req_ready <= '0;
            // Clear is applied first so a same-cycle timeout set overrides it.
            if (i_err_clr) o_err_stall <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_enable && any_valid && !i_ser_active) begin
                        o_ser_din         <= i_req_data[int'(pick)*WORD_WIDTH +: WORD_WIDTH];
                        o_grant_id        <= pick;
                        o_ser_start       <= 1'b1;
                        o_req_ready[pick] <= 1'b1;
                        state             <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    rr_ptr  <= IDX_W'(mod_inc(32'(o_grant_id), NUM_REQ));
                    tmo_cnt <= TMO_W'(ACT_TIMEOUT);
                    state   <= ST_WAIT_ACT;
                end
                ST_WAIT_ACT: begin
                    if (i_ser_active) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmo_cnt <= TMO_W'(1)) begin
                        tmo_cnt     <= '0;
                        o_err_stall <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_ser_active) begin
                        if (GAP_TICKS > 0) begin
                            gap_cnt <= GAP_W'(GAP_TICKS);
                            state   <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (i_tick) begin
                        if (gap_cnt <= GAP_W'(1)) state <= ST_IDLE;
                        else gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb: queue-based requesters, a behavioural
// serializer and a round-robin reference model built from the grant rules.
module tb_uart_tx_arb;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          tick;
    logic          err_clr;

    logic [NR-1:0]   valid0;
    logic [NR*8-1:0] data0;
    logic [NR-1:0]   ready0;
    logic [7:0]      din0;
    logic            start0;
    logic            act0;
    logic [1:0]      gid0;
    logic            busy0;
    logic            err0;

    logic [NR-1:0]   valid1;
    logic [NR*8-1:0] data1;
    logic [NR-1:0]   ready1;
    logic [7:0]      din1;
    logic            start1;
    logic            act1;
    logic [1:0]      gid1;
    logic            busy1;
    logic            err1;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(NR), .WORD_WIDTH(8), .GAP_TICKS(0), .ACT_TIMEOUT(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_enable(enable),
        .i_req_valid(valid0), .i_req_data(data0), .o_req_ready(ready0),
        .o_ser_din(din0), .o_ser_start(start0), .i_ser_active(act0),
        .o_grant_id(gid0), .o_busy(busy0), .o_err_stall(err0), .i_err_clr(err_clr)
    );

    uart_tx_arb #(.NUM_REQ(NR), .WORD_WIDTH(8), .GAP_TICKS(16), .ACT_TIMEOUT(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_enable(1'b1),
        .i_req_valid(valid1), .i_req_data(data1), .o_req_ready(ready1),
        .o_ser_din(din1), .o_ser_start(start1), .i_ser_active(act1),
        .o_grant_id(gid1), .o_busy(busy1), .o_err_stall(err1), .i_err_clr(err_clr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0]    q [NR][$];
    int            grants[$];
    int            m_ptr = 0;
    int            cyc = 0;
    int            n_starts = 0;
    int            dly = 0;
    int            flen = 0;
    int            fall_cyc = 0;
    int            pop_k = -1;
    bit            stall = 1'b0;
    bit            b2b_arm = 1'b0;
    bit            prev_start = 1'b0;
    logic [NR-1:0] prev_valid = '0;

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int i = 0; i < NR; i++)
            if (v[(p + i) % NR]) return (p + i) % NR;
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int k = 0; k < NR; k++)
            if (q[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        int g;
        bit launch;
        bit act_prev;
        launch = 1'b0;
        cyc++;
        if (!rst_n) begin
            act0 = 1'b0; dly = 0; flen = 0; m_ptr = 0; b2b_arm = 1'b0; pop_k = -1;
        end else begin
            if (pop_k >= 0 && q[pop_k].size() > 0) void'(q[pop_k].pop_front());
            pop_k = -1;
            act_prev = act0;
            if (start0) begin
                g = rr_pick(prev_valid, m_ptr);
                n_starts++;
                launch = 1'b1;
                chk("start_single_cycle", prev_start, 0);
                chk("start_while_active", act_prev, 0);
                chk("grant_id", gid0, g);
                chk("ready_onehot", ready0, (g >= 0) ? (32'd1 << g) : 32'd0);
                if (g >= 0 && q[g].size() > 0) chk("ser_din", din0, q[g][0]);
                if (b2b_arm) chk("b2b_idle_clocks", cyc - fall_cyc, 2);
                b2b_arm = 1'b0;
                if (g >= 0) begin
                    grants.push_back(g);
                    m_ptr = (g + 1) % NR;
                    pop_k = g;
                end
            end else if (ready0 != '0) begin
                chk("ready_without_start", ready0, 0);
            end
            // Behavioural serializer
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    act0 = 1'b1;
                    flen = $urandom_range(3, 12);
                end
            end else if (act0) begin
                flen--;
                if (flen == 0) begin
                    act0 = 1'b0;
                    if (enable && any_pending()) begin
                        fall_cyc = cyc;
                        b2b_arm  = 1'b1;
                    end
                end
            end
            if (launch && !stall) dly = $urandom_range(1, 3);
        end
        for (int k = 0; k < NR; k++) begin
            valid0[k]       = (q[k].size() > 0);
            data0[k*8 +: 8] = (q[k].size() > 0) ? q[k][0] : 8'h00;
        end
        prev_valid = valid0;
        prev_start = start0;
    end

    task automatic wait_idle();
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            done = !any_pending() && !busy0 && !act0 && (dly == 0) && (pop_k < 0);
        end
        chk("idle_reached", done, 1);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!start0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, start0, 1);
    endtask

    int exp_fair[6] = '{0, 1, 2, 3, 0, 1};
    int exp_rot[3]  = '{0, 2, 0};

    initial begin
        int lat;
        int ns;
        int n1, since16, ticks, len1, guard;
        bit arm1, counting, cnt_next;
        logic [NR-1:0] popm;

        rst_n = 1'b0; enable = 1'b1; err_clr = 1'b0; tick = 1'b0;
        valid1 = '0; data1 = '0; act1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready0, 0);
        chk("rst_start", start0, 0);
        chk("rst_din", din0, 0);
        chk("rst_grant", gid0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_err", err0, 0);
        chk("rst_busy_gap", busy1, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Fairness with all four pending
        @(posedge clk); #1;
        for (int k = 0; k < NR; k++) q[k].push_back(8'($urandom));
        q[0].push_back(8'($urandom));
        q[1].push_back(8'($urandom));
        wait_idle();
        chk("fair_count", grants.size(), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++) chk("fair_order", grants[i], exp_fair[i]);

        // Single requester
        grants.delete();
        @(posedge clk); #1 q[2].push_back(8'h5A);
        lat = 0;
        while (!start0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("single_latency", lat, 2);
        chk("single_grant", gid0, 2);
        chk("single_din", din0, 8'h5A);
        chk("single_ready", ready0, 4'b0100);
        wait_idle();

        // Rotation skip from pointer 3
        grants.delete();
        @(posedge clk); #1;
        q[0].push_back(8'h11); q[0].push_back(8'h22); q[2].push_back(8'h33);
        wait_idle();
        chk("rot_count", grants.size(), 3);
        for (int i = 0; i < 3 && i < grants.size(); i++) chk("rot_order", grants[i], exp_rot[i]);

        // Stall timeout
        chk("no_err_before_stall", err0, 0);
        stall = 1'b1;
        @(posedge clk); #1 q[1].push_back(8'hC3);
        wait_start("stall_start");
        repeat (4) @(negedge clk);
        chk("stall_err_early", err0, 0);
        @(negedge clk);
        chk("stall_err", err0, 1);
        chk("stall_idle", busy0, 0);
        repeat (3) @(negedge clk);
        chk("stall_sticky", err0, 1);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr", err0, 0);
        stall = 1'b0;
        wait_idle();

        // Enable dropped mid-frame
        @(posedge clk); #1;
        for (int k = 0; k < NR; k++) q[k].push_back(8'($urandom));
        wait_start("en_first_start");
        @(posedge clk); #1 enable = 1'b0;
        ns = n_starts;
        repeat (80) @(negedge clk);
        chk("en_no_new_grant", n_starts - ns, 0);
        chk("en_frame_done", busy0, 0);
        chk("en_line_idle", act0, 0);
        chk("en_words_held", valid0 != '0, 1);
        @(posedge clk); #1 enable = 1'b1;
        wait_idle();

        // Reset during WAIT_DONE
        @(posedge clk); #1 q[1].push_back(8'h7E);
        lat = 0;
        while (!act0 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("pre_reset_active", act0, 1);
        @(negedge clk);
        chk("pre_reset_busy", busy0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy0, 0);
        chk("midrst_grant", gid0, 0);
        chk("midrst_din", din0, 0);
        chk("midrst_start", start0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        grants.delete();
        @(posedge clk); #1;
        for (int k = 0; k < NR; k++) q[k].push_back(8'($urandom));
        wait_idle();
        if (grants.size() > 0) chk("post_reset_first_grant", grants[0], 0);
        else chk("post_reset_grants", grants.size(), 4);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            int k;
            @(posedge clk); #1;
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, NR - 1);
                if (q[k].size() < 3) q[k].push_back(8'($urandom));
            end
        end
        wait_idle();
        chk("no_err_random", err0, 0);

        // Inter-frame gap on the GAP_TICKS=16 instance
        n1 = 0; since16 = -1; ticks = 0; len1 = 0; guard = 0;
        arm1 = 1'b0; counting = 1'b0; cnt_next = 1'b0; popm = '0;
        @(posedge clk); #1;
        valid1 = 4'b0011;
        data1  = {8'h00, 8'h00, 8'hB2, 8'hA1};
        while (n1 < 2 && guard < 800) begin
            @(negedge clk);
            guard++;
            valid1 = valid1 & ~popm;
            popm   = ready1;
            if (since16 >= 0) since16++;
            if (start1) begin
                n1++;
                if (n1 == 1) begin
                    chk("gap_din1", din1, 8'hA1);
                    chk("gap_ready1", ready1, 4'b0001);
                end else begin
                    chk("gap_timing", since16, 2);
                    chk("gap_din2", din1, 8'hB2);
                    chk("gap_grant2", gid1, 1);
                end
            end
            cnt_next = 1'b0;
            if (arm1) begin
                act1 = 1'b1; len1 = 5; arm1 = 1'b0;
            end else if (act1) begin
                len1--;
                if (len1 == 0) begin
                    act1 = 1'b0; cnt_next = 1'b1;
                end
            end
            if (start1) arm1 = 1'b1;
            tick = ($urandom_range(0, 2) == 0);
            if (counting && tick) begin
                ticks++;
                if (ticks == 16) begin
                    since16 = 0; counting = 1'b0;
                end
            end
            if (cnt_next) begin
                counting = 1'b1; ticks = 0;
            end
        end
        tick = 1'b0;
        chk("gap_frames", n1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
